vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen_if.sv | 35 +++
 rtl/vga_pattern_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen_if
// Signal bundle between the VGA timing path and the pattern generator.
//   h_display / v_display : visible-window flags from the timing generators
//   mode                  : pattern select (0 solid, 1 bars, 2 checker, 3 box)
//   R_in / G_in / B_in    : 2-bit switch colour
//   R / G / B             : registered 4-bit pixel colour towards the DAC
//   x / y                 : current pixel coordinate
// Modports:
//   master : the pattern generator (pixel source)
//   slave  : the surrounding logic that drives timing/switches and takes pixels
// ---------------------------------------------------------------------------
interface vga_pattern_gen_if;
    logic       h_display;
    logic       v_display;
    logic [1:0] mode;
    logic [1:0] R_in;
    logic [1:0] G_in;
    logic [1:0] B_in;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;
    logic [9:0] x;
    logic [8:0] y;

    modport master (
        input  h_display, v_display, mode, R_in, G_in, B_in,
        output R, G, B, x, y
    );

    modport slave (
        output h_display, v_display, mode, R_in, G_in, B_in,
        input  R, G, B, x, y
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// Pixel source for the VGA path. Tracks the pixel coordinate from the
// h_display/v_display window flags and produces registered 4-bit R/G/B for
// one of four patterns: solid switch colour, eight colour bars, a 32-pixel
// checkerboard, or a box that bounces by STEP pixels per frame.
// Ports:
//   clk     : pixel clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   vga     : vga_pattern_gen_if.master (timing flags, mode, switches in;
//             colour and coordinate out)
// Colour output is one clk behind de/x/y, so the surrounding top level
// delays its sync pulses by one clk to stay aligned.
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX      = 32,
    parameter int STEP     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_pattern_gen_if.master vga
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [9:0]       X_MAX   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]       Y_MAX   = 9'(V_ACTIVE - 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(BAR_W - 1);
    // Box arithmetic is 11 bits wide so bx+STEP and bx+BOX cannot overflow.
    localparam logic [10:0]      BX_MAX  = 11'(H_ACTIVE - BOX);
    localparam logic [10:0]      BY_MAX  = 11'(V_ACTIVE - BOX);
    localparam logic [10:0]      STEP_W  = 11'(STEP);
    localparam logic [10:0]      BOX_W   = 11'(BOX);

    typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} x_dir_e;
    typedef enum logic {DOWN  = 1'b0, UP   = 1'b1} y_dir_e;

    logic             h_prev_reg;
    logic             v_prev_reg;
    logic             de;
    logic             h_fall;
    logic             frame_evt;

    logic [9:0]       x_reg;
    logic [8:0]       y_reg;
    logic [SUB_W-1:0] sub_reg;
    logic [2:0]       bar_reg;

    logic [1:0]       mode_q_reg;
    logic [1:0]       mode_q_next;
    logic [10:0]      bx_reg;
    logic [10:0]      bx_next;
    logic [10:0]      by_reg;
    logic [10:0]      by_next;
    x_dir_e           dir_x_reg;
    x_dir_e           dir_x_next;
    y_dir_e           dir_y_reg;
    y_dir_e           dir_y_next;

    logic [11:0]      rgb_reg;
    logic [11:0]      rgb_next;
    logic [11:0]      solid_rgb;
    logic             in_box;

    assign de        = vga.h_display & vga.v_display;
    assign h_fall    = h_prev_reg & ~vga.h_display;
    assign frame_evt = v_prev_reg & ~vga.v_display;

    // ---------------- switch colour expansion {v,v} ----------------
    logic [1:0] sw    [3];
    logic [3:0] solid [3];

    assign sw[0] = vga.R_in;
    assign sw[1] = vga.G_in;
    assign sw[2] = vga.B_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_expand
            assign solid[gi] = {sw[gi], sw[gi]};
        end
    endgenerate

    assign solid_rgb = {solid[0], solid[1], solid[2]};

    // ---------------- coordinate and bar counters ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_prev_reg <= 1'b0;
            v_prev_reg <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            sub_reg    <= '0;
            bar_reg    <= '0;
        end else begin
            h_prev_reg <= vga.h_display;
            v_prev_reg <= vga.v_display;

            // x and the bar counters share the same clear/advance conditions
            // so the bar index is always aligned with x.
            if (!vga.h_display) begin
                x_reg   <= '0;
                sub_reg <= '0;
                bar_reg <= '0;
            end else if (de) begin
                if (x_reg != X_MAX)
                    x_reg <= x_reg + 10'd1;
                if (sub_reg == SUB_MAX) begin
                    sub_reg <= '0;
                    // Hold on the last bar if the line runs long.
                    if (bar_reg != 3'd7)
                        bar_reg <= bar_reg + 3'd1;
                end else begin
                    sub_reg <= sub_reg + SUB_W'(1);
                end
            end

            // A v_display drop wins over a coincident line end.
            if (!vga.v_display)
                y_reg <= '0;
            else if (h_fall && y_reg != Y_MAX)
                y_reg <= y_reg + 9'd1;
        end
    end

    // ---------------- frame state: register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q_reg <= 2'd0;
            bx_reg     <= '0;
            by_reg     <= '0;
            dir_x_reg  <= RIGHT;
            dir_y_reg  <= DOWN;
        end else begin
            mode_q_reg <= mode_q_next;
            bx_reg     <= bx_next;
            by_reg     <= by_next;
            dir_x_reg  <= dir_x_next;
            dir_y_reg  <= dir_y_next;
        end
    end

    // ---------------- frame state: next state ----------------
    // Everything here moves only on the frame event, so a mode change or
    // box step never shows up part-way through a visible frame.
    always_comb begin
        mode_q_next = mode_q_reg;
        bx_next     = bx_reg;
        by_next     = by_reg;
        dir_x_next  = dir_x_reg;
        dir_y_next  = dir_y_reg;

        if (frame_evt) begin
            mode_q_next = vga.mode;

            if (dir_x_reg == RIGHT) begin
                if (bx_reg + STEP_W >= BX_MAX) begin
                    bx_next    = BX_MAX;
                    dir_x_next = LEFT;
                end else begin
                    bx_next = bx_reg + STEP_W;
                end
            end else begin
                if (bx_reg <= STEP_W) begin
                    bx_next    = '0;
                    dir_x_next = RIGHT;
                end else begin
                    bx_next = bx_reg - STEP_W;
                end
            end

            if (dir_y_reg == DOWN) begin
                if (by_reg + STEP_W >= BY_MAX) begin
                    by_next    = BY_MAX;
                    dir_y_next = UP;
                end else begin
                    by_next = by_reg + STEP_W;
                end
            end else begin
                if (by_reg <= STEP_W) begin
                    by_next    = '0;
                    dir_y_next = DOWN;
                end else begin
                    by_next = by_reg - STEP_W;
                end
            end
        end
    end

    // ---------------- pixel colour: output ----------------
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;  // white
            3'd1:    return 12'hFF0;  // yellow
            3'd2:    return 12'h0FF;  // cyan
            3'd3:    return 12'h0F0;  // green
            3'd4:    return 12'hF0F;  // magenta
            3'd5:    return 12'hF00;  // red
            3'd6:    return 12'h00F;  // blue
            default: return 12'h000;  // black
        endcase
    endfunction

    assign in_box = ({1'b0, x_reg} >= bx_reg) && ({1'b0, x_reg} < bx_reg + BOX_W) &&
                    ({2'b0, y_reg} >= by_reg) && ({2'b0, y_reg} < by_reg + BOX_W);

    always_comb begin
        rgb_next = 12'h000;
        if (de) begin
            case (mode_q_reg)
                2'd0:    rgb_next = solid_rgb;
                2'd1:    rgb_next = bar_colour(bar_reg);
                2'd2:    rgb_next = (x_reg[5] ^ y_reg[5]) ? 12'hFFF : 12'h000;
                default: rgb_next = in_box ? 12'hFFF : solid_rgb;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rgb_reg <= 12'h000;
        else
            rgb_reg <= rgb_next;
    end

    assign vga.R = rgb_reg[11:8];
    assign vga.G = rgb_reg[7:4];
    assign vga.B = rgb_reg[3:0];
    assign vga.x = x_reg;
    assign vga.y = y_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
// Directed bench for vga_pattern_gen. Lines and frames are shortened (few
// visible pixels, short blanking) except where a boundary needs the full
// width, so the whole run stays small. Expected colours are hand-derived.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    vga_pattern_gen_if vif ();

    vga_pattern_gen #(
        .H_ACTIVE (640),
        .V_ACTIVE (480),
        .BOX      (32),
        .STEP     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (vif.master)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ev       = 0;   // frame events seen since the last reset

    logic [11:0] pix [1024];
    logic [9:0]  xs  [1024];
    logic [8:0]  line_y;
    logic [11:0] blank_rgb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] rgb_out();
        return {vif.R, vif.G, vif.B};
    endfunction

    // One line: nvis cycles with h_display high, then nblank low.
    // pix[k] holds the colour produced for the k-th visible cycle.
    task automatic do_line(input int nvis, input int nblank);
        vif.h_display = 1'b1;
        for (int k = 0; k < nvis; k++) begin
            xs[k] = vif.x;
            if (k == 0) line_y = vif.y;
            tick();
            pix[k] = rgb_out();
        end
        vif.h_display = 1'b0;
        tick();
        blank_rgb = rgb_out();
        for (int k = 1; k < nblank; k++) tick();
    endtask

    // Vertical blank; the first cycle with v_display low is the frame event.
    task automatic vblank(input int n);
        vif.v_display = 1'b0;
        vif.h_display = 1'b0;
        for (int k = 0; k < n; k++) tick();
        ev++;
    endtask

    initial begin
        vif.h_display = 1'b1;
        vif.v_display = 1'b1;
        vif.mode      = 2'd3;
        vif.R_in      = 2'b10;
        vif.G_in      = 2'b01;
        vif.B_in      = 2'b11;

        // ---------------- reset held with de=1 ----------------
        for (int k = 0; k < 5; k++) tick();
        check("reset_rgb", 32'(rgb_out()), 32'h000);
        check("reset_x",   32'(vif.x), 32'd0);
        check("reset_y",   32'(vif.y), 32'd0);
        vif.h_display = 1'b0;
        vif.v_display = 1'b0;
        vif.mode      = 2'd0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // ---------------- frame 1: solid A/5/F ----------------
        vif.v_display = 1'b1;
        for (int l = 0; l < 3; l++) begin
            do_line(8, 4);
            if (l == 0) begin
                check("first_x",        32'(xs[0]), 32'd0);
                check("first_y",        32'(line_y), 32'd0);
                check("solid_px0",      32'(pix[0]), 32'hA5F);
                check("solid_px7",      32'(pix[7]), 32'hA5F);
                check("solid_x7",       32'(xs[7]), 32'd7);
                check("solid_blank",    32'(blank_rgb), 32'h000);
            end
            if (l == 2) check("line2_y", 32'(line_y), 32'd2);
        end
        vif.mode = 2'd1;
        vblank(4);

        // ---------------- frame 2: bars, x/y saturation ----------------
        vif.v_display = 1'b1;
        do_line(650, 4);
        check("bar_x79",   32'(pix[79]),  32'hFFF);
        check("bar_x80",   32'(pix[80]),  32'hFF0);
        check("bar_x559",  32'(pix[559]), 32'h00F);
        check("bar_x560",  32'(pix[560]), 32'h000);
        check("bar_x0",    32'(pix[0]),   32'hFFF);
        check("x_at_639",  32'(xs[639]),  32'd639);
        check("x_sat",     32'(xs[649]),  32'd639);
        for (int l = 1; l < 482; l++) begin
            do_line(2, 4);
            if (l == 1)   check("y_line1",   32'(line_y), 32'd1);
            if (l == 479) check("last_y",    32'(line_y), 32'd479);
            if (l == 479) check("last_px_x", 32'(xs[1]), 32'd1);
            if (l == 481) check("y_sat",     32'(line_y), 32'd479);
        end
        vif.mode = 2'd0;
        vblank(4);

        // ---------------- frame 3: mode 0 -> 2 at y=100 ----------------
        vif.v_display = 1'b1;
        for (int l = 0; l < 110; l++) begin
            if (l == 100) vif.mode = 2'd2;
            do_line(40, 4);
            if (l == 100) check("midframe_y100", 32'(pix[0]), 32'hA5F);
            if (l == 109) check("midframe_y109", 32'(pix[0]), 32'hA5F);
        end
        vblank(4);

        // ---------------- frame 4: checker ----------------
        vif.v_display = 1'b1;
        vif.mode = 2'd3;
        for (int l = 0; l < 33; l++) begin
            do_line(40, 4);
            if (l == 0) begin
                check("chk_31_0", 32'(pix[31]), 32'h000);
                check("chk_32_0", 32'(pix[32]), 32'hFFF);
            end
            if (l == 32) begin
                check("chk_32_32", 32'(pix[32]), 32'h000);
                check("chk_0_32",  32'(pix[0]),  32'hFFF);
            end
        end
        vblank(4);

        // ---------------- frame 5: box at (8,8) ----------------
        check("box_bx_f4", 32'(dut.bx_reg), 32'd8);
        vif.v_display = 1'b1;
        for (int l = 0; l < 10; l++) begin
            if (l == 8) vif.R_in = 2'b01;
            do_line(48, 4);
            if (l == 7) check("box_above", 32'(pix[8]), 32'hA5F);
            if (l == 9) begin
                check("box_left_out", 32'(pix[7]),  32'h55F);
                check("box_left_in",  32'(pix[8]),  32'hFFF);
                check("box_right_in", 32'(pix[39]), 32'hFFF);
                check("box_right_out",32'(pix[40]), 32'h55F);
            end
        end
        vblank(4);

        // ---------------- fast frames up to 305 ----------------
        while (ev < 305) begin
            vif.v_display = 1'b1;
            tick();
            vblank(1);
            if (ev == 224) begin
                check("by_f224", 32'(dut.by_reg), 32'd448);
                check("bx_f224", 32'(dut.bx_reg), 32'd448);
            end
            if (ev == 225) check("by_f225", 32'(dut.by_reg), 32'd446);
            if (ev == 303) check("bx_f303", 32'(dut.bx_reg), 32'd606);
            if (ev == 304) begin
                check("bx_f304",  32'(dut.bx_reg), 32'd608);
                check("dirx_f304",32'(dut.dir_x_reg), 32'd1);
                check("by_f304",  32'(dut.by_reg), 32'd288);
            end
            if (ev == 305) check("bx_f305", 32'(dut.bx_reg), 32'd606);
        end

        // ---------------- reset mid-line ----------------
        vif.v_display = 1'b1;
        vif.h_display = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("pre_reset_rgb", 32'(rgb_out()), 32'h55F);
        reset_n = 1'b0;
        #1;
        check("async_rgb", 32'(rgb_out()), 32'h000);
        check("async_x",   32'(vif.x), 32'd0);
        vif.h_display = 1'b0;
        vif.v_display = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        ev = 0;
        tick();
        check("rst_bx", 32'(dut.bx_reg), 32'd0);

        vif.v_display = 1'b1;
        for (int l = 0; l < 2; l++) begin
            do_line(8, 4);
            if (l == 0) begin
                check("post_rst_x",  32'(xs[0]), 32'd0);
                check("post_rst_px", 32'(pix[3]), 32'h55F);
            end
        end
        vblank(4);
        check("post_rst_bx", 32'(dut.bx_reg), 32'd2);
        check("post_rst_by", 32'(dut.by_reg), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Backstop in case the stimulus ever stalls.
    initial begin
        #20ms;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
